// File: rtl/divider_unit.sv
// divider_unit: 32-bit signed/unsigned divide and remainder, one restoring quotient bit per cycle.
// Divide-by-zero and signed overflow complete immediately without iterating.
module divider_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_i,
    input  logic [1:0]  Div_Operation_i,
    input  logic [31:0] Dividend_i,
    input  logic [31:0] Divisor_i,
    output logic        Busy_o,
    output logic        Done_o,
    output logic [31:0] Result_o,
    output logic        Zero_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvs;
    logic        op_rem, neg_q, neg_r;
    logic        is_signed, div_zero, ovf, accept, fits;
    logic [31:0] a_mag, b_mag, special_res, rem_nx, quo_nx, fin;
    logic [32:0] diff;

    always_comb begin
        is_signed   = ~Div_Operation_i[0];
        a_mag       = (is_signed && Dividend_i[31]) ? -Dividend_i : Dividend_i;
        b_mag       = (is_signed && Divisor_i[31]) ? -Divisor_i : Divisor_i;
        div_zero    = Divisor_i == 32'd0;
        ovf         = is_signed && Dividend_i == 32'h8000_0000 && Divisor_i == 32'hFFFF_FFFF;
        special_res = div_zero ? (Div_Operation_i[1] ? Dividend_i : 32'hFFFF_FFFF)
                               : (Div_Operation_i[1] ? 32'd0 : 32'h8000_0000);
        accept      = Start_i && state != CALC;
        diff        = {rem, quo[31]} - {1'b0, dvs};
        fits        = ~diff[32];
        rem_nx      = fits ? diff[31:0] : {rem[30:0], quo[31]};
        quo_nx      = {quo[30:0], fits};
        fin         = op_rem ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            quo      <= 32'd0;
            rem      <= 32'd0;
            dvs      <= 32'd0;
            op_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            Busy_o   <= 1'b0;
            Done_o   <= 1'b0;
            Result_o <= 32'd0;
            Zero_o   <= 1'b1;
        end else begin
            Done_o <= 1'b0;
            if (accept) begin
                op_rem <= Div_Operation_i[1];
                if (div_zero || ovf) begin
                    state    <= DONE;
                    Busy_o   <= 1'b0;
                    Done_o   <= 1'b1;
                    Result_o <= special_res;
                    Zero_o   <= special_res == 32'd0;
                end else begin
                    state  <= CALC;
                    Busy_o <= 1'b1;
                    cnt    <= 5'd0;
                    quo    <= a_mag;
                    rem    <= 32'd0;
                    dvs    <= b_mag;
                    neg_q  <= is_signed && (Dividend_i[31] ^ Divisor_i[31]);
                    neg_r  <= is_signed && Dividend_i[31];
                end
            end else if (state == CALC) begin
                quo <= quo_nx;
                rem <= rem_nx;
                cnt <= cnt + 5'd1;
                // Final iteration writes the signed-corrected result directly.
                if (cnt == 5'd31) begin
                    state    <= DONE;
                    Busy_o   <= 1'b0;
                    Done_o   <= 1'b1;
                    Result_o <= fin;
                    Zero_o   <= fin == 32'd0;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: directed vectors against a transaction-level divide model plus literal checks.
module tb_divider_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start_i = 1'b0;
    logic [1:0]  Div_Operation_i = 2'b00;
    logic [31:0] Dividend_i = 32'd0;
    logic [31:0] Divisor_i = 32'd0;
    logic        Busy_o, Done_o, Zero_o;
    logic [31:0] Result_o;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    divider_unit dut (
        .clk(clk), .reset(reset), .Start_i(Start_i), .Div_Operation_i(Div_Operation_i),
        .Dividend_i(Dividend_i), .Divisor_i(Divisor_i), .Busy_o(Busy_o), .Done_o(Done_o),
        .Result_o(Result_o), .Zero_o(Zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {completes_immediately, result} from plain arithmetic.
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] v;
        if (b == 0) return {1'b1, op[1] ? a : 32'hFFFF_FFFF};
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, op[1] ? 32'd0 : 32'h8000_0000};
        sa = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
        sb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        v = op[1] ? r[31:0] : q[31:0];
        return {1'b0, v};
    endfunction

    logic [32:0] m_now;
    assign m_now = model(Div_Operation_i, Dividend_i, Divisor_i);

    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_res = 32'd0, m_pend = 32'd0;
    int          m_left = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= 32'd0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (Start_i && !m_busy) begin
                if (m_now[32]) begin
                    m_res  <= m_now[31:0];
                    m_done <= 1'b1;
                end else begin
                    m_pend <= m_now[31:0];
                    m_left <= 32;
                    m_busy <= 1'b1;
                end
            end else if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_res  <= m_pend;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", Busy_o, m_busy);
            chk("done", Done_o, m_done);
            chk("result", Result_o, m_res);
            chk("zero", Zero_o, m_res == 32'd0);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start_i = 1'b1;
        Div_Operation_i = op;
        Dividend_i = a;
        Divisor_i = b;
    endtask

    task automatic wait_done(input string nm, input logic [31:0] exp, input int lat, input int n0);
        int n = n0;
        do begin
            @(negedge clk);
            n++;
            Start_i = 1'b0;
        end while (!Done_o && n < 40);
        chk({nm, "_lat"}, n, lat);
        chk({nm, "_res"}, Result_o, exp);
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        issue(op, a, b);
        wait_done(nm, exp, lat, 0);
    endtask

    initial begin
        int d;
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", Busy_o, 0);
        chk("rst_done", Done_o, 0);
        chk("rst_res", Result_o, 0);
        chk("rst_zero", Zero_o, 1);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset = 1'b1;

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
        chk("divu_zero", Zero_o, 0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("divu_by0", 2'b01, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", 2'b11, 32'h1234, 32'd0, 32'h0000_1234, 1);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        chk("rem_ovf_zero", Zero_o, 1);
        run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        run_op("div_0_5", 2'b00, 32'd0, 32'd5, 32'd0, 33);
        run_op("remu_5_max", 2'b11, 32'd5, 32'hFFFF_FFFF, 32'd5, 33);
        run_op("div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);

        // A start pulse mid-calculation must be ignored entirely.
        issue(2'b01, 32'd50, 32'd5);
        repeat (5) begin
            @(negedge clk);
            Start_i = 1'b0;
        end
        issue(2'b01, 32'd9, 32'd3);
        @(negedge clk);
        Start_i = 1'b0;
        wait_done("divu_50_5", 32'd10, 33, 6);
        run_op("divu_9_3_b2b", 2'b01, 32'd9, 32'd3, 32'd3, 33);
        repeat (3) @(negedge clk);

        issue(2'b01, 32'd100, 32'd7);
        repeat (10) begin
            @(negedge clk);
            Start_i = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", Busy_o, 0);
        chk("mid_rst_done", Done_o, 0);
        chk("mid_rst_res", Result_o, 0);
        chk("mid_rst_zero", Zero_o, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        d = 0;
        repeat (40) begin
            @(negedge clk);
            d += int'(Done_o);
        end
        chk("no_done_after_rst", d, 0);
        run_op("divu_after_rst", 2'b01, 32'd1000, 32'd10, 32'd100, 33);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Start_i  input  1  request; sampled on rising clk edge, accepted only in IDLE or DONE.
REQ-005 Div_Operation_i  input  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-006 Dividend_i  input  32  dividend, two's complement for DIV/REM.
REQ-007 Divisor_i  input  32  divisor, two's complement for DIV/REM.
REQ-008 Busy_o  output  1  high while an iterative division is in progress (CALC).
REQ-009 Done_o  output  1  single-cycle pulse marking Result_o valid for a new operation.
REQ-010 Result_o  output  32  quotient or remainder per captured operation; held until next completion.
REQ-011 Zero_o  output  1  high when Result_o equals 0, registered with Result_o.

Function
REQ-012 States SHALL be IDLE, CALC and DONE; all outputs SHALL be registered.
REQ-013 On an accepted Start_i, operands and operation SHALL be captured; later input changes have no effect until completion.
REQ-014 Start_i in CALC SHALL be ignored: no capture, no state change, no extra Done_o.
REQ-015 Normal path: IDLE/DONE -> CALC, 32 iterations at one quotient bit per cycle (restoring, unsigned magnitudes), then CALC -> DONE.
REQ-016 Latency: Done_o SHALL be high exactly 33 cycles after the accepting edge for the normal path.
REQ-017 Busy_o SHALL be high for exactly the 32 CALC cycles and low otherwise.
REQ-018 Divisor zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend; no CALC; Done_o high 1 cycle after acceptance.
REQ-019 Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): DIV result 0x80000000, REM result 0; no CALC; Done_o high 1 cycle after acceptance.
REQ-020 Signed ops: divide magnitudes; quotient negated when operand signs differ; remainder takes dividend's sign; quotient truncates toward zero.
REQ-021 Invariant: dividend = quotient*divisor + remainder, |remainder| < |divisor| for nonzero divisor.
REQ-022 DONE SHALL last one cycle, then return to IDLE unless Start_i is accepted in that cycle (back-to-back, no bubble).
REQ-023 Result_o and Zero_o SHALL update only on the cycle Done_o rises; they hold otherwise.
REQ-024 Start_i and reset both active: reset SHALL win.

Reset
REQ-025 reset low SHALL immediately force IDLE, Busy_o=0, Done_o=0, Result_o=0, Zero_o=1, iteration counter=0, independent of clk.
REQ-026 Reset mid-CALC SHALL abandon the operation; no Done_o after reset release until a new Start_i is accepted.
REQ-027 First Start_i SHALL be accepted on the first rising edge with reset high.

Verification
REQ-028 DIVU 100/7: Start at edge k -> Busy_o high k+1..k+32, Done_o at k+33, Result_o=14, Zero_o=0; REMU same operands -> 2.
REQ-029 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
REQ-030 DIVU 0x1234/0 -> Done_o next cycle, Result_o=0xFFFFFFFF, Busy_o never high; REMU 0x1234/0 -> 0x00001234.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 cycle; REM same -> 0 with Zero_o=1.
REQ-032 Start DIVU 50/5, pulse Start_i with 9/3 at CALC cycle 5 -> single Done_o, Result_o=10; Start in DONE cycle -> next Done_o 33 cycles later.
REQ-033 Reset low at CALC cycle 10 -> outputs at reset values at once; after release no Done_o for 40 cycles without Start_i.
